// File: rtl/mask_mod.sv
// M-ary ASK modulator: each accepted symbol scales a square-wave carrier
// for SYM_LEN clocks, with carrier phase carried across back-to-back symbols.
module mask_mod #(
  parameter int SYM_BITS  = 1,
  parameter int CARR_HALF = 5,
  parameter int SYM_LEN   = 25,
  parameter int OUT_W     = 8,
  parameter int AMP_STEP  = 127
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       en,
  input  logic                       sym_valid,
  input  logic [SYM_BITS-1:0]        sym_data,
  output logic                       sym_ready,
  output logic signed [OUT_W-1:0]    y,
  output logic                       carrier,
  output logic                       busy,
  output logic                       underrun
);

  localparam int PH_W = (CARR_HALF > 1) ? $clog2(CARR_HALF) : 1;
  localparam int SC_W = $clog2(SYM_LEN);
  localparam logic [PH_W-1:0] PH_LAST = PH_W'(CARR_HALF - 1);
  localparam logic [SC_W-1:0] SC_LAST = SC_W'(SYM_LEN - 1);

  if (SYM_BITS < 1 || SYM_BITS > 4) begin : g_bad_sym_bits
    $error("mask_mod: SYM_BITS must be in 1..4");
  end
  if (CARR_HALF < 1) begin : g_bad_carr_half
    $error("mask_mod: CARR_HALF must be >= 1");
  end
  if (SYM_LEN < 2) begin : g_bad_sym_len
    $error("mask_mod: SYM_LEN must be >= 2");
  end
  if (AMP_STEP * ((2 ** SYM_BITS) - 1) > (2 ** (OUT_W - 1)) - 1) begin : g_bad_amp
    $error("mask_mod: AMP_STEP * (2^SYM_BITS-1) exceeds the OUT_W signed range");
  end

  typedef enum logic {IDLE, RUN} state_t;

  state_t                state;
  logic [SYM_BITS-1:0]   cur_sym;
  logic [SC_W-1:0]       sym_cnt;
  logic [PH_W-1:0]       ph;
  logic                  pol;
  logic                  sym_end;
  logic                  xfer;

  // Peak amplitude fits OUT_W by the elaboration check, so no saturation.
  function automatic logic signed [OUT_W-1:0] level(input logic [SYM_BITS-1:0] s,
                                                    input logic p);
    logic signed [OUT_W-1:0] mag;
    mag = signed'(OUT_W'(s) * OUT_W'(AMP_STEP));
    return p ? mag : -mag;
  endfunction

  assign sym_end   = (sym_cnt == SC_LAST);
  assign sym_ready = rst & en & ((state == IDLE) | sym_end);
  assign xfer      = sym_valid & sym_ready;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= IDLE;
      cur_sym  <= '0;
      sym_cnt  <= '0;
      ph       <= '0;
      pol      <= 1'b0;
      y        <= '0;
      carrier  <= 1'b0;
      busy     <= 1'b0;
      underrun <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          y        <= '0;
          carrier  <= 1'b0;
          busy     <= 1'b0;
          underrun <= 1'b0;
          if (xfer) begin
            cur_sym <= sym_data;
            sym_cnt <= '0;
            ph      <= '0;
            pol     <= 1'b1;
            state   <= RUN;
          end
        end
        RUN: begin
          if (!en) begin
            // Abort: in-flight symbol is dropped, outputs go quiet next cycle.
            state    <= IDLE;
            sym_cnt  <= '0;
            ph       <= '0;
            pol      <= 1'b0;
            y        <= '0;
            carrier  <= 1'b0;
            busy     <= 1'b0;
            underrun <= 1'b0;
          end else begin
            y        <= level(cur_sym, pol);
            carrier  <= pol;
            busy     <= 1'b1;
            underrun <= 1'b0;
            if (ph == PH_LAST) begin
              ph  <= '0;
              pol <= ~pol;
            end else begin
              ph <= ph + PH_W'(1);
            end
            if (!sym_end) begin
              sym_cnt <= sym_cnt + SC_W'(1);
            end else if (xfer) begin
              // Seamless reload; carrier phase keeps running.
              cur_sym <= sym_data;
              sym_cnt <= '0;
            end else begin
              state    <= IDLE;
              sym_cnt  <= '0;
              underrun <= 1'b1;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
